// File: rtl/io_port_responder.sv
// Memory-mapped port: 32-bit PORT_OUT, synchronised 8-bit PORT_IN with change IRQ.
// Latency WAIT_STATES+1 cycles to a 1-cycle Ready; the requester holds its request until Ready.
module io_port_responder #(
    parameter logic [31:0] ADDR_BASE   = 32'hFFFF0000,
    parameter int          WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Address,
    input  logic [31:0] WriteData,
    input  logic        MemWrite,
    input  logic        MemRead,
    output logic        Hit,
    output logic        Ready,
    output logic [31:0] ReadData,
    input  logic [7:0]  PortIn,
    output logic [31:0] PortOut,
    output logic        IRQ
);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    localparam logic [2:0] WAIT_LOAD = 3'(WAIT_STATES);

    state_t      state, nextState;
    logic [2:0]  waitCnt, nextWaitCnt;
    logic [31:0] portOutReg;
    logic        ctrlIe;
    logic        statChg, statOvr;
    logic        nextChg, nextOvr;
    logic [7:0]  syncMeta, syncQ, prevQ;
    logic [1:0]  warmCnt;
    logic        readyReg;
    logic [31:0] readDataReg;
    logic [31:0] regRdData;
    logic        accept;
    logic        commitWrite;
    logic        pinChange;
    logic        unusedAddrLow;

    // Byte lanes are not decoded; every access is a full word.
    assign unusedAddrLow = ^Address[1:0];

    assign Hit         = (Address[31:4] == ADDR_BASE[31:4]);
    assign accept      = Hit && (MemRead || MemWrite);
    assign commitWrite = (state == RESP) && MemWrite;
    assign pinChange   = (warmCnt == 2'd2) && (syncQ != prevQ);

    always_comb begin
        nextState   = state;
        nextWaitCnt = waitCnt;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (WAIT_STATES == 0) begin
                        nextState = RESP;
                    end else begin
                        nextState   = WAIT;
                        nextWaitCnt = WAIT_LOAD;
                    end
                end
            end
            WAIT: begin
                if (!accept) begin
                    nextState   = IDLE;
                    nextWaitCnt = 3'd0;
                end else if (waitCnt <= 3'd1) begin
                    nextState   = RESP;
                    nextWaitCnt = 3'd0;
                end else begin
                    nextWaitCnt = waitCnt - 3'd1;
                end
            end
            RESP:    nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    always_comb begin
        regRdData = 32'd0;
        case (Address[3:2])
            2'd0: regRdData = portOutReg;
            2'd1: regRdData = {24'd0, syncQ};
            2'd2: regRdData = {30'd0, statOvr, statChg};
            2'd3: regRdData = {31'd0, ctrlIe};
            default: regRdData = 32'd0;
        endcase
    end

    // Write-1-to-clear first, then a pin change sets on top of it so set wins.
    always_comb begin
        nextChg = statChg;
        nextOvr = statOvr;
        if (commitWrite && (Address[3:2] == 2'd2)) begin
            nextChg = statChg & ~WriteData[0];
            nextOvr = statOvr & ~WriteData[1];
        end
        if (pinChange) begin
            nextChg = 1'b1;
            if (statChg) begin
                nextOvr = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            waitCnt     <= 3'd0;
            portOutReg  <= 32'd0;
            ctrlIe      <= 1'b0;
            statChg     <= 1'b0;
            statOvr     <= 1'b0;
            syncMeta    <= 8'd0;
            syncQ       <= 8'd0;
            prevQ       <= 8'd0;
            warmCnt     <= 2'd0;
            readyReg    <= 1'b0;
            readDataReg <= 32'd0;
        end else begin
            state    <= nextState;
            waitCnt  <= nextWaitCnt;
            syncMeta <= PortIn;
            syncQ    <= syncMeta;
            prevQ    <= syncQ;
            if (warmCnt != 2'd2) begin
                warmCnt <= warmCnt + 2'd1;
            end
            statChg <= nextChg;
            statOvr <= nextOvr;
            if (commitWrite && (Address[3:2] == 2'd0)) begin
                portOutReg <= WriteData;
            end
            if (commitWrite && (Address[3:2] == 2'd3)) begin
                ctrlIe <= WriteData[0];
            end
            // Load data is sampled before any write of the same access commits.
            readyReg    <= (nextState == RESP);
            readDataReg <= (nextState == RESP) ? regRdData : 32'd0;
        end
    end

    assign Ready    = readyReg;
    assign ReadData = readDataReg;
    assign PortOut  = portOutReg;
    assign IRQ      = ctrlIe & statChg;

endmodule

// File: doc/io_port_responder.md
IO_PORT_RESPONDER -- requirements
Module: io_port_responder

Interface
REQ-001 Parameter ADDR_BASE, default 32'hFFFF0000, is the base of the 16-byte register window; bits [3:0] are zero.
REQ-002 Parameter WAIT_STATES, default 1, range 0..7, sets the number of WAIT cycles before a response.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 Address  input  32  byte address from the processor data bus.
REQ-006 WriteData  input  32  store data.
REQ-007 MemWrite  input  1  store request; held until Ready.
REQ-008 MemRead  input  1  load request; held until Ready.
REQ-009 Hit  output  1  combinational; 1 when Address[31:4] == ADDR_BASE[31:4].
REQ-010 Ready  output  1  registered; 1-cycle response strobe.
REQ-011 ReadData  output  32  registered load data; valid when Ready=1.
REQ-012 PortIn  input  8  asynchronous external pins.
REQ-013 PortOut  output  32  registered output port.
REQ-014 IRQ  output  1  CTRL.IE AND STATUS.CHG.

Function
REQ-015 Register map (Address[3:2]): 0 PORT_OUT RW; 1 PORT_IN RO; 2 STATUS (bit0 CHG, bit1 OVR, write-1-to-clear); 3 CTRL (bit0 IE, RW); other bits read 0.
REQ-016 Address[1:0] is ignored; all accesses are full-word.
REQ-017 FSM states are IDLE, WAIT, RESP.
REQ-018 IDLE -> WAIT when Hit and (MemRead or MemWrite) and WAIT_STATES>0; IDLE -> RESP directly when WAIT_STATES=0.
REQ-019 WAIT counts WAIT_STATES cycles using a 3-bit counter loaded on entry, then -> RESP.
REQ-020 If the request drops or Hit drops during WAIT: -> IDLE, no write, no Ready.
REQ-021 RESP lasts exactly 1 cycle with Ready=1; write effects commit on the edge ending RESP; then -> IDLE unconditionally.
REQ-022 Request-to-Ready latency is WAIT_STATES+1 cycles; back-to-back requests require 1 IDLE cycle between them.
REQ-023 MemRead and MemWrite both high: write is performed, and ReadData returns the pre-write register value.
REQ-024 ReadData = 0 whenever Ready=0.
REQ-025 Load data is captured on the edge entering RESP.
REQ-026 PortIn passes through a 2-flop synchronizer (sync); PORT_IN reads {24'b0, sync}.
REQ-027 Change detection compares sync against a registered copy (prev) every cycle.
REQ-028 On sync != prev: CHG is set; OVR is also set if CHG was already 1.
REQ-029 Change detection is disabled for the first 2 cycles after reset release (2-bit warm-up counter); prev tracks sync during warm-up.
REQ-030 STATUS write: bits with WriteData=1 are cleared.
REQ-031 Set and clear of the same STATUS bit in one cycle: set wins.
REQ-032 Writes to PORT_IN are ignored but still produce Ready.
REQ-033 Hit=0 requests are never acknowledged; the FSM stays in IDLE.

Reset
REQ-034 When reset=1 at a clock edge: state IDLE; counters 0; PortOut, STATUS, CTRL, sync, prev, ReadData = 0; Ready = 0; IRQ = 0.
REQ-035 Reset asserted mid-transaction aborts it with no register write and no Ready.
REQ-036 Reset takes priority over every other event in the same cycle.

Verification
REQ-037 WAIT_STATES=1, store 32'hA5A5_0001 to 0xFFFF0000 -> Ready at cycle 2 after request; PortOut = 32'hA5A50001 the following cycle.
REQ-038 PortIn 0x00 -> 0x3C after warm-up -> STATUS reads 0x1 within 3 cycles; PORT_IN reads 0x3C; a second change before clear -> STATUS reads 0x3.
REQ-039 CTRL=1, CHG=1 -> IRQ=1; store 0x1 to STATUS -> IRQ=0 the cycle after RESP; a concurrent pin change keeps CHG=1.
REQ-040 Load from 0xFFFF0010 (Hit=0) held 10 cycles -> Ready stays 0; load from 0xFFFF0003 -> returns PORT_OUT.
REQ-041 Store request dropped during WAIT -> no Ready, PortOut unchanged; reset pulse during WAIT -> IDLE, all outputs 0.
REQ-042 WAIT_STATES=0 with back-to-back loads -> Ready on cycles 1, 3, 5, ...; MemRead+MemWrite together to CTRL -> old value returned, new value stored.
